wall_clock_bcd: RTL

12-hour BCD wall clock (hh:mm:ss plus AM/PM) that consumes the one-cycle-per-second enable pulse from the 1000 Hz divider. It advances once per `ena` pulse and supports a synchronous time-load port with range checking. It also emits one-cycle minute and hour rollover strobes. All state is clocked by the same 1000 Hz `clk` as the divider, so there is no clock crossing.

---
 rtl/wall_clock_bcd.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/wall_clock_bcd.sv
// wall_clock_bcd
// 12-hour BCD wall clock (hh:mm:ss + AM/PM). It advances one second per `ena`
// pulse and accepts a range-checked synchronous time load. It also emits
// registered one-cycle minute, hour and load-error strobes.
//
// Ports
//   clk        rising-edge clock (same domain as the one-second divider)
//   reset      asynchronous, active-high; clock returns to 12:00:00 AM
//   ena        advance one second this cycle (level, no edge detection)
//   load       load set_* this cycle if legal; takes priority over ena
//   set_hh     BCD hours to load, legal 01..12
//   set_mm     BCD minutes to load, legal 00..59
//   set_ss     BCD seconds to load, legal 00..59
//   set_pm     AM/PM to load (1 = PM)
//   hh/mm/ss   registered BCD time
//   pm         registered AM/PM flag (1 = PM)
//   min_tick   high for the first cycle showing ss = 00 after an advance
//   hour_tick  high for the first cycle showing mm:ss = 00:00 after an advance
//   load_err   high for the cycle after a rejected load
//
// Strobe protocol: every strobe is a registered single-cycle pulse. It is
// valid in the cycle after the edge that caused it. There is no ready/back-
// pressure; consumers must sample every cycle.
module wall_clock_bcd (
  input  logic       clk,
  input  logic       reset,
  input  logic       ena,
  input  logic       load,
  input  logic [7:0] set_hh,
  input  logic [7:0] set_mm,
  input  logic [7:0] set_ss,
  input  logic       set_pm,
  output logic [7:0] hh,
  output logic [7:0] mm,
  output logic [7:0] ss,
  output logic       pm,
  output logic       min_tick,
  output logic       hour_tick,
  output logic       load_err
);

  logic [3:0] ss_ones, ss_tens, mm_ones, mm_tens, hh_ones, hh_tens;
  logic [3:0] ss_ones_n, ss_tens_n, mm_ones_n, mm_tens_n, hh_ones_n, hh_tens_n;
  logic       pm_n, min_tick_n, hour_tick_n, load_err_n;

  logic adv, ss_tens_en, mm_ones_en, mm_tens_en, hh_en;
  logic set_ok, set_hh_ok;

  // A load in the same cycle discards the advance.
  assign adv = ena & ~load;

  // Cascaded digit enables: each stage is the previous enable ANDed with
  // that previous digit's terminal count.
  assign ss_tens_en = adv        & (ss_ones == 4'd9);
  assign mm_ones_en = ss_tens_en & (ss_tens == 4'd5);
  assign mm_tens_en = mm_ones_en & (mm_ones == 4'd9);
  assign hh_en      = mm_tens_en & (mm_tens == 4'd5);

  assign set_hh_ok = ((set_hh[7:4] == 4'd0) && (set_hh[3:0] != 4'd0) && (set_hh[3:0] <= 4'd9)) ||
                     ((set_hh[7:4] == 4'd1) && (set_hh[3:0] <= 4'd2));

  assign set_ok = set_hh_ok &&
                  (set_mm[7:4] <= 4'd5) && (set_mm[3:0] <= 4'd9) &&
                  (set_ss[7:4] <= 4'd5) && (set_ss[3:0] <= 4'd9);

  always_comb begin
    ss_ones_n   = ss_ones;
    ss_tens_n   = ss_tens;
    mm_ones_n   = mm_ones;
    mm_tens_n   = mm_tens;
    hh_ones_n   = hh_ones;
    hh_tens_n   = hh_tens;
    pm_n        = pm;
    min_tick_n  = 1'b0;
    hour_tick_n = 1'b0;
    load_err_n  = 1'b0;

    if (load) begin
      if (set_ok) begin
        ss_ones_n = set_ss[3:0];
        ss_tens_n = set_ss[7:4];
        mm_ones_n = set_mm[3:0];
        mm_tens_n = set_mm[7:4];
        hh_ones_n = set_hh[3:0];
        hh_tens_n = set_hh[7:4];
        pm_n      = set_pm;
      end else begin
        load_err_n = 1'b1;
      end
    end else begin
      if (adv)
        ss_ones_n = (ss_ones == 4'd9) ? 4'd0 : ss_ones + 4'd1;
      if (ss_tens_en)
        ss_tens_n = (ss_tens == 4'd5) ? 4'd0 : ss_tens + 4'd1;
      if (mm_ones_en)
        mm_ones_n = (mm_ones == 4'd9) ? 4'd0 : mm_ones + 4'd1;
      if (mm_tens_en)
        mm_tens_n = (mm_tens == 4'd5) ? 4'd0 : mm_tens + 4'd1;
      if (hh_en) begin
        if (hh_tens == 4'd1 && hh_ones == 4'd2) begin
          // 12 -> 01 keeps the meridiem.
          hh_tens_n = 4'd0;
          hh_ones_n = 4'd1;
        end else if (hh_tens == 4'd1 && hh_ones == 4'd1) begin
          // 11 -> 12 is where AM/PM flips.
          hh_ones_n = 4'd2;
          pm_n      = ~pm;
        end else if (hh_ones == 4'd9) begin
          hh_tens_n = 4'd1;
          hh_ones_n = 4'd0;
        end else begin
          hh_ones_n = hh_ones + 4'd1;
        end
      end
      min_tick_n  = mm_ones_en;
      hour_tick_n = hh_en;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ss_ones   <= 4'd0;
      ss_tens   <= 4'd0;
      mm_ones   <= 4'd0;
      mm_tens   <= 4'd0;
      hh_ones   <= 4'd2;
      hh_tens   <= 4'd1;
      pm        <= 1'b0;
      min_tick  <= 1'b0;
      hour_tick <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      ss_ones   <= ss_ones_n;
      ss_tens   <= ss_tens_n;
      mm_ones   <= mm_ones_n;
      mm_tens   <= mm_tens_n;
      hh_ones   <= hh_ones_n;
      hh_tens   <= hh_tens_n;
      pm        <= pm_n;
      min_tick  <= min_tick_n;
      hour_tick <= hour_tick_n;
      load_err  <= load_err_n;
    end
  end

  assign hh = {hh_tens, hh_ones};
  assign mm = {mm_tens, mm_ones};
  assign ss = {ss_tens, ss_ones};

endmodule
